axis_trigger_sequencer: RTL and testbench
=========================================

# axis_trigger_sequencer

Run controller for the trigger event stream: accepts the 128-bit `{time[61:0], data[65:0]}` events produced by the trigger front end and decides which reach the downstream AXI4-Stream consumer (DMA/FIFO). Provides channel masking, per-event holdoff, an event-count limit and drop accounting. It sits between the trigger front end, whose source has no `tready`, and a back-pressuring sink, with start/stop and config driven from the CPU register bank.

## Interface
- `DATA_WIDTH`, 66, width of the trigger data field (low bits of event)
- `AXIS_TDATA_WIDTH`, 128, event width (time + data)
- `CNTR_WIDTH`, 32, width of holdoff, limit and status counters
- `aclk`  in  1  clock; all logic on rising edge
- `areset`  in  1  synchronous, active-high reset
- `cfg_mask`  in  DATA_WIDTH  channel qualify mask, latched on start
- `cfg_holdoff`  in  CNTR_WIDTH  dead cycles after each captured event, latched on start
- `cfg_limit`  in  CNTR_WIDTH  events per run, 0 = unlimited, latched on start
- `start`  in  1  one-cycle arm pulse
- `stop`  in  1  one-cycle abort pulse
- `s_axis_tdata`  in  AXIS_TDATA_WIDTH  event from trigger front end
- `s_axis_tvalid`  in  1  event present (no tready; never stalled)
- `m_axis_tdata`  out  AXIS_TDATA_WIDTH  forwarded event
- `m_axis_tvalid`  out  1  output slot full
- `m_axis_tready`  in  1  sink accepts
- `sts_state`  out  2  current state
- `sts_events`  out  CNTR_WIDTH  events captured this run
- `sts_drops`  out  CNTR_WIDTH  qualified events lost to a full slot
- `busy`  out  1  state is ARMED or HOLDOFF

## Operation
- States (encoding): IDLE=0, ARMED=1, HOLDOFF=2, DONE=3.
- Qualified event: `s_axis_tvalid & |(s_axis_tdata[DATA_WIDTH-1:0] & mask_reg)`.
- Slot free this cycle: `~m_axis_tvalid | m_axis_tready`.
- IDLE/DONE + `start` -> ARMED. Latch cfg, clear `sts_events`, `sts_drops`, holdoff counter. `start` in ARMED/HOLDOFF is ignored.
- `stop` in any state -> IDLE. `stop` wins over `start` and over an event in the same cycle. The output slot is not flushed; it drains normally.
- ARMED, qualified event, slot free -> capture: load slot, `sts_events`+1.
  - If the new count equals a nonzero limit -> DONE.
  - Else if holdoff != 0 -> HOLDOFF with counter = holdoff.
  - Else stay ARMED.
- ARMED, qualified event, slot full and not draining -> drop: `sts_drops`+1, no holdoff, not counted toward limit.
- HOLDOFF: counter decrements each cycle; when counter==1 -> ARMED. All events in HOLDOFF are ignored and not counted as drops.
- Unqualified events are ignored in every state. All events are ignored in IDLE and DONE.
- Counters saturate at 2^CNTR_WIDTH-1.
- Slot: `m_axis_tvalid` set on capture, cleared on `tvalid & tready` with no same-cycle capture. A same-cycle capture and drain keeps `tvalid`=1 with the new data. `tdata` is held stable while `tvalid & ~tready`.

## Timing
- Reset values: state IDLE, `m_axis_tvalid`=0, `m_axis_tdata`=0, `sts_events`=0, `sts_drops`=0, `busy`=0, all latched cfg = 0.
- Latency: event at cycle N -> `m_axis_tvalid`/`tdata` at N+1.
- `start` at N -> ARMED at N+1; first capturable event at N+1.
- Holdoff H>0: capture at N -> next capturable event at N+H+1.
- Status outputs are registered and reflect updates one cycle after the causing event.
- Reset mid-run: state returns to IDLE; the slot is cleared (the pending event is lost).

## Structure
- Shared package `axis_trigger_pkg`: state encodings and the default width constants. Shared with the trigger front end.
- One sub-module, `axis_event_slot`: the single-entry output register with capture/drain logic and a `free` output.
- FSM, counters and qualification stay in the top module.

## Test plan
- Reset, then `start` with mask=all ones, holdoff=0, limit=0; events on 3 consecutive cycles with tready=1 -> 3 outputs at N+1..N+3, `sts_events`=3, state ARMED.
- Holdoff=4, continuous qualified events -> captures at cycles N, N+5, N+10; no drops counted.
- Limit=2, events each cycle -> exactly 2 forwarded, state DONE, later events ignored. A second `start` clears `sts_events` to 0.
- tready=0, holdoff=0, 4 qualified events -> first held stable in slot, `sts_drops`=3. tready=1 with an event in the same cycle -> slot replaced, tvalid stays 1.
- mask=0x1 with event data=0x2 -> not forwarded, no drop. Data bit 65 set with mask bit 65 -> forwarded.
- `start` and `stop` in the same cycle while a slot is pending -> state IDLE, pending event still delivered on tready.

Source files
------------

// File: rtl/axis_trigger_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_trigger_pkg
// Description : Shared state encodings and default widths for the trigger path.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_trigger_pkg;

    localparam int unsigned DATA_WIDTH_DEF       = 66;
    localparam int unsigned AXIS_TDATA_WIDTH_DEF = 128;
    localparam int unsigned CNTR_WIDTH_DEF       = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_HOLDOFF = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/axis_event_slot.sv
`default_nettype none
// ============================================================================
// Module      : axis_event_slot
// Description : Single-entry AXI4-Stream output register with capture/drain.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_event_slot
    import axis_trigger_pkg::*;
#(
    parameter int unsigned WIDTH = AXIS_TDATA_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             tready_i,
    output logic             tvalid_o,
    output logic [WIDTH-1:0] tdata_o,
    output logic             free_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    // A capture in the same cycle as a drain simply overwrites the slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (capture_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end else if (valid_q && tready_i) begin
            valid_q <= 1'b0;
        end
    end

    assign tvalid_o = valid_q;
    assign tdata_o  = data_q;
    assign free_o   = ~valid_q | tready_i;

endmodule
`default_nettype wire

// File: rtl/axis_trigger_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : axis_trigger_sequencer
// Description : Run controller gating trigger events onto an AXI4-Stream sink.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_trigger_sequencer
    import axis_trigger_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = DATA_WIDTH_DEF,
    parameter int unsigned AXIS_TDATA_WIDTH = AXIS_TDATA_WIDTH_DEF,
    parameter int unsigned CNTR_WIDTH       = CNTR_WIDTH_DEF
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic [DATA_WIDTH-1:0]       cfg_mask,
    input  logic [CNTR_WIDTH-1:0]       cfg_holdoff,
    input  logic [CNTR_WIDTH-1:0]       cfg_limit,
    input  logic                        start,
    input  logic                        stop,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [1:0]                  sts_state,
    output logic [CNTR_WIDTH-1:0]       sts_events,
    output logic [CNTR_WIDTH-1:0]       sts_drops,
    output logic                        busy
);

    localparam logic [CNTR_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNTR_WIDTH-1:0] CNT_ONE = CNTR_WIDTH'(1);

    state_t                  state_q;
    logic                    busy_q;
    logic [DATA_WIDTH-1:0]   mask_q;
    logic [CNTR_WIDTH-1:0]   holdoff_q;
    logic [CNTR_WIDTH-1:0]   limit_q;
    logic [CNTR_WIDTH-1:0]   hcnt_q;
    logic [CNTR_WIDTH-1:0]   events_q;
    logic [CNTR_WIDTH-1:0]   drops_q;
    logic [CNTR_WIDTH-1:0]   events_d;
    logic [CNTR_WIDTH-1:0]   drops_d;

    logic w_qual;
    logic w_free;
    logic w_capture;
    logic w_drop;

    assign w_qual    = s_axis_tvalid & (|(s_axis_tdata[DATA_WIDTH-1:0] & mask_q));
    assign w_capture = (state_q == ST_ARMED) & w_qual & w_free & ~stop;
    assign w_drop    = (state_q == ST_ARMED) & w_qual & ~w_free & ~stop;
    assign events_d  = (events_q == CNT_MAX) ? events_q : events_q + CNT_ONE;
    assign drops_d   = (drops_q == CNT_MAX) ? drops_q : drops_q + CNT_ONE;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            mask_q    <= '0;
            holdoff_q <= '0;
            limit_q   <= '0;
            hcnt_q    <= '0;
            events_q  <= '0;
            drops_q   <= '0;
        end else if (stop) begin
            // Abort leaves the output slot alone so a pending event still drains.
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q   <= ST_ARMED;
                        busy_q    <= 1'b1;
                        mask_q    <= cfg_mask;
                        holdoff_q <= cfg_holdoff;
                        limit_q   <= cfg_limit;
                        hcnt_q    <= '0;
                        events_q  <= '0;
                        drops_q   <= '0;
                    end
                end
                ST_ARMED: begin
                    if (w_capture) begin
                        events_q <= events_d;
                        if ((limit_q != '0) && (events_d == limit_q)) begin
                            state_q <= ST_DONE;
                            busy_q  <= 1'b0;
                        end else if (holdoff_q != '0) begin
                            state_q <= ST_HOLDOFF;
                            hcnt_q  <= holdoff_q;
                        end
                    end else if (w_drop) begin
                        drops_q <= drops_d;
                    end
                end
                ST_HOLDOFF: begin
                    hcnt_q <= hcnt_q - CNT_ONE;
                    if (hcnt_q == CNT_ONE) begin
                        state_q <= ST_ARMED;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    axis_event_slot #(
        .WIDTH     (AXIS_TDATA_WIDTH)
    ) u_slot (
        .clk       (aclk),
        .rst       (areset),
        .capture_i (w_capture),
        .data_i    (s_axis_tdata),
        .tready_i  (m_axis_tready),
        .tvalid_o  (m_axis_tvalid),
        .tdata_o   (m_axis_tdata),
        .free_o    (w_free)
    );

    assign sts_state  = state_q;
    assign sts_events = events_q;
    assign sts_drops  = drops_q;
    assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_trigger_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_trigger_sequencer
// Description : Directed vector bench for the trigger run controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_trigger_sequencer;

    localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_HOLD = 2'd2, S_DONE = 2'd3;
    localparam logic [65:0] MASK_ALL = {66{1'b1}};
    localparam logic [65:0] MASK_B65 = 66'h2_0000_0000_0000_0001;

    logic         aclk = 1'b0;
    logic         areset = 1'b1;
    logic [65:0]  cfg_mask = '0;
    logic [31:0]  cfg_holdoff = '0;
    logic [31:0]  cfg_limit = '0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [127:0] s_axis_tdata = '0;
    logic         s_axis_tvalid = 1'b0;
    logic [127:0] m_axis_tdata;
    logic         m_axis_tvalid;
    logic         m_axis_tready = 1'b0;
    logic [1:0]   sts_state;
    logic [31:0]  sts_events;
    logic [31:0]  sts_drops;
    logic         busy;

    int checks = 0;
    int failures = 0;

    axis_trigger_sequencer dut (
        .aclk          (aclk),
        .areset        (areset),
        .cfg_mask      (cfg_mask),
        .cfg_holdoff   (cfg_holdoff),
        .cfg_limit     (cfg_limit),
        .start         (start),
        .stop          (stop),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .sts_state     (sts_state),
        .sts_events    (sts_events),
        .sts_drops     (sts_drops),
        .busy          (busy)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        string        tag;
        logic [65:0]  mask;
        logic [31:0]  hold;
        logic [31:0]  lim;
        logic         st, sp, tv, tr;
        logic [127:0] td;
        logic         mv;
        logic [127:0] md;
        logic [1:0]   state;
        logic [31:0]  ev, dr;
        logic         bz;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [127:0] ev_word(input int k);
        return {62'(k), 66'(k)};
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cycle(input logic st, input logic sp, input logic tv,
                         input logic [127:0] td, input logic tr);
        start = st; stop = sp; s_axis_tvalid = tv; s_axis_tdata = td; m_axis_tready = tr;
        @(posedge aclk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic mv, input logic [127:0] md,
                              input logic [1:0] st, input logic [31:0] ev,
                              input logic [31:0] dr, input logic bz);
        chk({tag, ".tvalid"}, 128'(m_axis_tvalid), 128'(mv));
        chk({tag, ".tdata"},  m_axis_tdata, md);
        chk({tag, ".state"},  128'(sts_state), 128'(st));
        chk({tag, ".events"}, 128'(sts_events), 128'(ev));
        chk({tag, ".drops"},  128'(sts_drops), 128'(dr));
        chk({tag, ".busy"},   128'(busy), 128'(bz));
    endtask

    task automatic add(input string tag, input logic [65:0] mask, input logic [31:0] hold,
                       input logic [31:0] lim, input logic st, input logic sp, input logic tv,
                       input logic [127:0] td, input logic tr, input logic mv,
                       input logic [127:0] md, input logic [1:0] state,
                       input logic [31:0] ev, input logic [31:0] dr, input logic bz);
        vec_t v;
        v.tag = tag; v.mask = mask; v.hold = hold; v.lim = lim;
        v.st = st; v.sp = sp; v.tv = tv; v.td = td; v.tr = tr;
        v.mv = mv; v.md = md; v.state = state; v.ev = ev; v.dr = dr; v.bz = bz;
        vecs.push_back(v);
    endtask

    initial begin
        logic [127:0] b65;
        logic [127:0] last_md;
        b65 = {62'd9, 66'h2_0000_0000_0000_0000};

        // Basic capture, ignored re-start, back-pressure drops, swap, masking.
        add("start",  MASK_ALL, 0, 0, 1,0,0, '0,          1, 0, '0,          S_ARMED, 0, 0, 1);
        add("ev1",    MASK_ALL, 0, 0, 0,0,1, ev_word(1),  1, 1, ev_word(1),  S_ARMED, 1, 0, 1);
        add("ev2",    MASK_ALL, 0, 0, 1,0,1, ev_word(2),  1, 1, ev_word(2),  S_ARMED, 2, 0, 1);
        add("ev3",    MASK_ALL, 0, 0, 0,0,1, ev_word(3),  1, 1, ev_word(3),  S_ARMED, 3, 0, 1);
        add("drain",  MASK_ALL, 0, 0, 0,0,0, '0,          1, 0, ev_word(3),  S_ARMED, 3, 0, 1);
        add("bpcap",  MASK_ALL, 0, 0, 0,0,1, ev_word(4),  0, 1, ev_word(4),  S_ARMED, 4, 0, 1);
        add("drop1",  MASK_ALL, 0, 0, 0,0,1, ev_word(5),  0, 1, ev_word(4),  S_ARMED, 4, 1, 1);
        add("drop2",  MASK_ALL, 0, 0, 0,0,1, ev_word(6),  0, 1, ev_word(4),  S_ARMED, 4, 2, 1);
        add("drop3",  MASK_ALL, 0, 0, 0,0,1, ev_word(7),  0, 1, ev_word(4),  S_ARMED, 4, 3, 1);
        add("swap",   MASK_ALL, 0, 0, 0,0,1, ev_word(8),  1, 1, ev_word(8),  S_ARMED, 5, 3, 1);
        add("drain2", MASK_ALL, 0, 0, 0,0,0, '0,          1, 0, ev_word(8),  S_ARMED, 5, 3, 1);
        add("stop",   MASK_ALL, 0, 0, 0,1,0, '0,          1, 0, ev_word(8),  S_IDLE,  5, 3, 0);
        add("idleev", MASK_ALL, 0, 0, 0,0,1, ev_word(9),  1, 0, ev_word(8),  S_IDLE,  5, 3, 0);
        add("mstart", MASK_B65, 0, 0, 1,0,0, '0,          1, 0, ev_word(8),  S_ARMED, 0, 0, 1);
        add("unqual", MASK_B65, 0, 0, 0,0,1, 128'h2,      1, 0, ev_word(8),  S_ARMED, 0, 0, 1);
        add("bit65",  MASK_B65, 0, 0, 0,0,1, b65,         1, 1, b65,         S_ARMED, 1, 0, 1);
        add("stop2",  MASK_B65, 0, 0, 0,1,0, '0,          1, 0, b65,         S_IDLE,  1, 0, 0);

        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        expect_out("reset", 0, '0, S_IDLE, 0, 0, 0);
        areset = 1'b0;

        foreach (vecs[i]) begin
            cfg_mask = vecs[i].mask; cfg_holdoff = vecs[i].hold; cfg_limit = vecs[i].lim;
            cycle(vecs[i].st, vecs[i].sp, vecs[i].tv, vecs[i].td, vecs[i].tr);
            expect_out(vecs[i].tag, vecs[i].mv, vecs[i].md, vecs[i].state,
                       vecs[i].ev, vecs[i].dr, vecs[i].bz);
        end

        // Holdoff of 4 under a continuous event stream: captures every 5th cycle.
        cfg_mask = MASK_ALL; cfg_holdoff = 32'd4; cfg_limit = '0;
        cycle(1, 0, 0, '0, 1);
        expect_out("hstart", 0, b65, S_ARMED, 0, 0, 1);
        for (int k = 0; k <= 10; k++) begin
            cycle(0, 0, 1, ev_word(100 + k), 1);
            last_md = ev_word(100 + (k / 5) * 5);
            expect_out($sformatf("hold%0d", k), (k % 5) == 0, last_md,
                       ((k % 5) == 4) ? S_ARMED : S_HOLD, 32'(k / 5 + 1), 0, 1);
        end
        cycle(0, 1, 0, '0, 1);
        expect_out("hstop", 0, ev_word(110), S_IDLE, 3, 0, 0);

        // Limit of 2: run ends in DONE, later events ignored, restart clears count.
        cfg_holdoff = '0; cfg_limit = 32'd2;
        cycle(1, 0, 0, '0, 1);
        expect_out("lstart", 0, ev_word(110), S_ARMED, 0, 0, 1);
        cycle(0, 0, 1, ev_word(120), 1);
        expect_out("lim1", 1, ev_word(120), S_ARMED, 1, 0, 1);
        cycle(0, 0, 1, ev_word(121), 1);
        expect_out("lim2", 1, ev_word(121), S_DONE, 2, 0, 0);
        cycle(0, 0, 1, ev_word(122), 1);
        expect_out("lim3", 0, ev_word(121), S_DONE, 2, 0, 0);
        cycle(0, 0, 1, ev_word(123), 1);
        expect_out("lim4", 0, ev_word(121), S_DONE, 2, 0, 0);
        cycle(1, 0, 0, '0, 1);
        expect_out("lrestart", 0, ev_word(121), S_ARMED, 0, 0, 1);
        cycle(0, 1, 0, '0, 1);
        expect_out("lstop", 0, ev_word(121), S_IDLE, 0, 0, 0);

        // start+stop together with a pending slot: stop wins, slot drains later.
        cfg_limit = '0;
        cycle(1, 0, 0, '0, 0);
        expect_out("pstart", 0, ev_word(121), S_ARMED, 0, 0, 1);
        cycle(0, 0, 1, ev_word(200), 0);
        expect_out("pcap", 1, ev_word(200), S_ARMED, 1, 0, 1);
        cycle(1, 1, 1, ev_word(201), 0);
        expect_out("pss", 1, ev_word(200), S_IDLE, 1, 0, 0);
        cycle(0, 0, 0, '0, 0);
        expect_out("phold", 1, ev_word(200), S_IDLE, 1, 0, 0);
        cycle(0, 0, 0, '0, 1);
        expect_out("pdrain", 0, ev_word(200), S_IDLE, 1, 0, 0);

        // Reset mid-run discards the pending slot entry.
        cycle(1, 0, 0, '0, 0);
        expect_out("rstart", 0, ev_word(200), S_ARMED, 0, 0, 1);
        cycle(0, 0, 1, ev_word(300), 0);
        expect_out("rcap", 1, ev_word(300), S_ARMED, 1, 0, 1);
        areset = 1'b1;
        cycle(0, 0, 0, '0, 0);
        expect_out("rmid", 0, '0, S_IDLE, 0, 0, 0);
        areset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
